// File: rtl/arb_requester.sv
// Per-client pending-transaction tracker that drives arbiter requests and
// flags overflow, starvation and illegal grants with sticky error bits.
module arb_requester #(
  parameter int CLIENTS  = 32,
  parameter int MAX_PEND = 7,
  parameter int TIMEOUT  = 31
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [CLIENTS-1:0] push,
  input  logic [CLIENTS-1:0] grant,
  input  logic               clear_err,
  output logic [CLIENTS-1:0] request,
  output logic [CLIENTS-1:0] pend_full,
  output logic [CLIENTS-1:0] starve,
  output logic               overflow,
  output logic               spurious_grant
);

  localparam int CW = $clog2(MAX_PEND + 1);
  localparam int AW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0]      CNT_MAX = CW'(MAX_PEND);
  localparam logic [CW-1:0]      CNT_ONE = CW'(1);
  localparam logic [AW-1:0]      AGE_MAX = AW'(TIMEOUT);
  localparam logic [AW-1:0]      AGE_ONE = AW'(1);
  localparam logic [CLIENTS-1:0] LSB_ONE = CLIENTS'(1);

  logic [CLIENTS-1:0] ovf_set;
  logic [CLIENTS-1:0] spur_set;
  logic               multi_grant;
  logic               overflow_q, overflow_d;
  logic               spurious_q, spurious_d;

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_grant = (grant & (grant - LSB_ONE)) != '0;

  genvar gi;
  generate
    for (gi = 0; gi < CLIENTS; gi++) begin : gen_client
      logic [CW-1:0] cnt_q, cnt_d;
      logic [AW-1:0] age_q, age_d;
      logic          starve_q, starve_d;
      logic          req;
      logic          consume;
      logic          ovf_c;

      assign req     = cnt_q != '0;
      assign consume = grant[gi] & req;

      always_comb begin
        cnt_d    = cnt_q;
        ovf_c    = 1'b0;
        age_d    = age_q;
        starve_d = starve_q & ~clear_err;

        // A push paired with a consumed grant is a net no-op, even at full.
        if (push[gi] && !consume) begin
          if (cnt_q == CNT_MAX) begin
            ovf_c = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else if (!push[gi] && consume) begin
          cnt_d = cnt_q - CNT_ONE;
        end

        if (!req || grant[gi]) begin
          age_d = '0;
        end else if (age_q != AGE_MAX) begin
          age_d = age_q + AGE_ONE;
        end

        if (age_d == AGE_MAX) begin
          starve_d = 1'b1;
        end
      end

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          cnt_q    <= '0;
          age_q    <= '0;
          starve_q <= 1'b0;
        end else begin
          cnt_q    <= cnt_d;
          age_q    <= age_d;
          starve_q <= starve_d;
        end
      end

      assign ovf_set[gi]   = ovf_c;
      assign spur_set[gi]  = grant[gi] & ~req;
      assign request[gi]   = req;
      assign pend_full[gi] = cnt_q == CNT_MAX;
      assign starve[gi]    = starve_q;
    end
  endgenerate

  always_comb begin
    overflow_d = (|ovf_set) | (overflow_q & ~clear_err);
    spurious_d = (|spur_set) | multi_grant | (spurious_q & ~clear_err);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow_q <= 1'b0;
      spurious_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
      spurious_q <= spurious_d;
    end
  end

  assign overflow       = overflow_q;
  assign spurious_grant = spurious_q;

endmodule

// File: tb/tb_arb_requester.sv
// Directed self-checking bench for arb_requester with default parameters.
module tb_arb_requester;

  localparam int CLIENTS = 32;

  logic               clock;
  logic               reset;
  logic [CLIENTS-1:0] push;
  logic [CLIENTS-1:0] grant;
  logic               clear_err;
  logic [CLIENTS-1:0] request;
  logic [CLIENTS-1:0] pend_full;
  logic [CLIENTS-1:0] starve;
  logic               overflow;
  logic               spurious_grant;

  int checks = 0;
  int errors = 0;

  arb_requester #(.CLIENTS(CLIENTS), .MAX_PEND(7), .TIMEOUT(31)) dut (
    .clock          (clock),
    .reset          (reset),
    .push           (push),
    .grant          (grant),
    .clear_err      (clear_err),
    .request        (request),
    .pend_full      (pend_full),
    .starve         (starve),
    .overflow       (overflow),
    .spurious_grant (spurious_grant)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_clear();
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
  endtask

  initial begin
    reset     = 1'b0;
    push      = '0;
    grant     = '0;
    clear_err = 1'b0;
    tick();
    tick();
    chk("rst_request", request, '0);
    chk("rst_pend_full", pend_full, '0);
    chk("rst_starve", starve, '0);
    chk("rst_overflow", overflow, 0);
    chk("rst_spurious", spurious_grant, 0);
    reset = 1'b1;
    tick();

    // Single push retired by a grant three cycles later
    push[4] = 1'b1;
    chk("lat_c0_req", request[4], 0);
    tick();
    push = '0;
    chk("lat_c1_req", request[4], 1);
    tick();
    chk("lat_c2_req", request[4], 1);
    tick();
    chk("lat_c3_req", request[4], 1);
    grant[4] = 1'b1;
    tick();
    grant = '0;
    chk("lat_c4_req", request[4], 0);
    chk("lat_c4_starve", starve, '0);
    chk("lat_c4_spur", spurious_grant, 0);
    $display("scenario push_grant done");

    // Starvation after TIMEOUT ungranted cycles
    push[4] = 1'b1;
    tick();
    push = '0;
    chk("stv_c1_req", request[4], 1);
    repeat (30) tick();
    chk("stv_c31_starve", starve[4], 0);
    tick();
    chk("stv_c32_starve", starve, 64'h10);
    chk("stv_c32_req", request[4], 1);
    grant[4] = 1'b1;
    tick();
    grant = '0;
    chk("stv_retire_req", request[4], 0);
    chk("stv_sticky", starve[4], 1);
    do_clear();
    chk("stv_cleared", starve[4], 0);
    $display("scenario starve done");

    // Grant in the TIMEOUT-th cycle prevents starvation
    push[4] = 1'b1;
    tick();
    push = '0;
    repeat (30) tick();
    grant[4] = 1'b1;
    tick();
    grant = '0;
    chk("nstv_c32_starve", starve[4], 0);
    chk("nstv_c32_req", request[4], 0);
    tick();
    chk("nstv_after", starve, '0);
    $display("scenario starve_avoided done");

    // Fill client 2 to MAX_PEND, then overflow with an eighth push
    push[2] = 1'b1;
    repeat (6) tick();
    chk("full_6_pf", pend_full[2], 0);
    tick();
    chk("full_7_pf", pend_full[2], 1);
    chk("full_7_ovf", overflow, 0);
    tick();
    push = '0;
    chk("full_8_ovf", overflow, 1);
    chk("full_8_pf", pend_full[2], 1);
    grant[2] = 1'b1;
    for (int g = 1; g <= 7; g++) begin
      tick();
      if (g == 1) chk("drain_pf_drop", pend_full[2], 0);
      if (g == 6) chk("drain_6_req", request[2], 1);
      if (g == 7) chk("drain_7_req", request[2], 0);
    end
    grant = '0;
    chk("ovf_sticky", overflow, 1);
    do_clear();
    chk("ovf_cleared", overflow, 0);
    $display("scenario overflow done");

    // Push with grant at full count: stays full, no overflow
    push[3] = 1'b1;
    repeat (7) tick();
    chk("fullpg_pf", pend_full[3], 1);
    grant[3] = 1'b1;
    tick();
    push  = '0;
    grant = '0;
    chk("fullpg_pf_after", pend_full[3], 1);
    chk("fullpg_ovf", overflow, 0);
    grant[3] = 1'b1;
    repeat (7) tick();
    grant = '0;
    chk("fullpg_drain", request[3], 0);
    $display("scenario full_push_grant done");

    // Grant to an idle client
    grant[9] = 1'b1;
    tick();
    grant = '0;
    chk("spur_flag", spurious_grant, 1);
    chk("spur_req9", request[9], 0);
    do_clear();
    chk("spur_cleared", spurious_grant, 0);
    grant[9]  = 1'b1;
    clear_err = 1'b1;
    tick();
    grant     = '0;
    clear_err = 1'b0;
    chk("spur_set_wins", spurious_grant, 1);
    do_clear();
    chk("spur_cleared2", spurious_grant, 0);
    $display("scenario spurious done");

    // Two grant bits in one cycle, both legitimate per client
    push[10] = 1'b1;
    push[11] = 1'b1;
    tick();
    push = '0;
    chk("multi_req_pre", request[11:10], 2'b11);
    chk("multi_spur_pre", spurious_grant, 0);
    grant[10] = 1'b1;
    grant[11] = 1'b1;
    tick();
    grant = '0;
    chk("multi_spur", spurious_grant, 1);
    chk("multi_req_post", request[11:10], 2'b00);
    do_clear();
    $display("scenario multi_grant done");

    // Push and grant together on an idle client
    push[12]  = 1'b1;
    grant[12] = 1'b1;
    tick();
    push  = '0;
    grant = '0;
    chk("pgidle_req", request[12], 1);
    chk("pgidle_spur", spurious_grant, 1);
    grant[12] = 1'b1;
    tick();
    grant = '0;
    chk("pgidle_drain", request[12], 0);
    do_clear();
    $display("scenario push_grant_idle done");

    // cnt=2 with simultaneous push and grant stays at 2
    push[5] = 1'b1;
    tick();
    tick();
    grant[5] = 1'b1;
    tick();
    push = '0;
    chk("hold_req", request[5], 1);
    tick();
    chk("hold_after1", request[5], 1);
    tick();
    grant = '0;
    chk("hold_after2", request[5], 0);
    chk("hold_spur", spurious_grant, 0);
    $display("scenario push_grant_hold done");

    // Asynchronous reset mid-operation
    push[1] = 1'b1;
    repeat (3) tick();
    push = '0;
    repeat (29) tick();
    chk("ar_starve_pre", starve[1], 1);
    chk("ar_req_pre", request[1], 1);
    grant[20] = 1'b1;
    tick();
    grant = '0;
    chk("ar_spur_pre", spurious_grant, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_request", request, '0);
    chk("ar_pend_full", pend_full, '0);
    chk("ar_starve", starve, '0);
    chk("ar_overflow", overflow, 0);
    chk("ar_spur", spurious_grant, 0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("ar_post1", request[1], 0);
    tick();
    chk("ar_post2", request[1], 0);
    push[1] = 1'b1;
    tick();
    push = '0;
    chk("ar_repush", request[1], 1);
    $display("scenario async_reset done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arb_requester.md
ARB_REQUESTER -- requirements
Module: arb_requester

Interface
REQ-001 Parameter CLIENTS, default 32, SHALL be the number of request/grant lanes.
REQ-002 Parameter MAX_PEND, default 7, SHALL be the max outstanding transactions per client; counter width clog2(MAX_PEND+1).
REQ-003 Parameter TIMEOUT, default 31, SHALL be the max consecutive ungranted request cycles before starvation.
REQ-004 Single clock; reset is asynchronous and active-low, ports named as below.
REQ-005 clock  in  1  sole clock, all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 push  in  CLIENTS  push[i]=1 enqueues one transaction for client i this cycle.
REQ-008 grant  in  CLIENTS  grant from arbiter, expected at most one-hot.
REQ-009 clear_err  in  1  clears all sticky error flags.
REQ-010 request  out  CLIENTS  request to arbiter, request[i]=1 while client i has pending work.
REQ-011 pend_full  out  CLIENTS  client i pending count equals MAX_PEND.
REQ-012 starve  out  CLIENTS  sticky, client i waited TIMEOUT cycles without grant.
REQ-013 overflow  out  1  sticky, push dropped at full count.
REQ-014 spurious_grant  out  1  sticky, illegal grant observed.

Function
REQ-015 Each client SHALL hold a registered pending count cnt[i]; request[i] = (cnt[i]!=0) and pend_full[i] = (cnt[i]==MAX_PEND), both from registers only; no combinational path from grant or push to any output.
REQ-016 Push-to-request latency SHALL be 1 cycle: push in cycle N -> request high in cycle N+1 if cnt was 0.
REQ-017 A grant SHALL be consumed in the same cycle grant[i] and request[i] are both high; cnt decrements at that edge.
REQ-018 cnt update per client: push only -> +1; grant only with cnt!=0 -> -1; push and grant with cnt!=0 -> unchanged; neither -> unchanged.
REQ-019 Push with cnt==MAX_PEND and no grant SHALL leave cnt unchanged and set overflow; push at MAX_PEND with grant SHALL leave cnt at MAX_PEND, no overflow.
REQ-020 grant[i] with cnt[i]==0 SHALL not change cnt (push same cycle still increments to 1) and SHALL set spurious_grant.
REQ-021 More than one grant bit set in a cycle SHALL set spurious_grant; each bit is still processed per REQ-018/020.
REQ-022 request[i] SHALL remain high until the grant retiring its last pending transaction; it never drops without a grant.
REQ-023 Per-client age counter: cleared when request[i]=0 or grant[i]=1; otherwise +1, saturating at TIMEOUT.
REQ-024 starve[i] SHALL set at the edge where age reaches TIMEOUT, i.e. after TIMEOUT consecutive cycles of request[i]=1, grant[i]=0; grant in the TIMEOUT-th cycle prevents it.
REQ-025 Sticky flags SHALL clear at the edge after clear_err=1; a set condition in the same cycle wins over clear.
REQ-026 Clients SHALL be fully independent except for the shared overflow and spurious_grant flags.

Reset
REQ-027 While reset=0: all cnt and age counters 0; request, pend_full, starve 0; overflow and spurious_grant 0.
REQ-028 Reset assertion mid-operation SHALL discard all pending transactions immediately (asynchronously); first push after deassertion behaves per REQ-016.

Verification
REQ-029 push[4] pulse cycle 0, grant[4] cycle 3 -> request[4] high cycles 1-3, low cycle 4, starve[4]=0.
REQ-030 push[4] cycle 0, no grant -> request[4] high from cycle 1; starve[4] high from cycle 32; grant[4] at cycle 31 instead -> starve[4] stays 0.
REQ-031 8 consecutive push[2], no grant -> cnt reaches 7, pend_full[2]=1 after 7th, overflow=1 after 8th; 7 grants then return request[2] to 0.
REQ-032 grant[9] with request[9]=0 -> spurious_grant=1 next cycle, cnt[9] stays 0; clear_err -> flag 0 next cycle.
REQ-033 cnt[5]=2, push[5] and grant[5] same cycle -> cnt stays 2, request[5] stays high.
REQ-034 reset=0 asserted with cnt[1]=3, starve[1]=1 -> all outputs 0 immediately; after release request[1]=0 until next push.
